// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared widths, opcodes, flag bit positions and sequencer state codes |
// | for the ALU issue arbiter.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int OP_W   = 8;

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_MUL    = 8'h03;
  localparam logic [7:0] OP_AND    = 8'h04;
  localparam logic [7:0] OP_OR     = 8'h05;
  localparam logic [7:0] OP_NOT    = 8'h06;
  localparam logic [7:0] OP_XOR    = 8'h07;
  localparam logic [7:0] OP_LSHIFT = 8'h08;
  localparam logic [7:0] OP_RSHIFT = 8'h09;

  // Bit positions inside the 4-bit response flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // True for opcodes the ALU implements; anything else is answered with an error.
  function automatic logic op_is_legal(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
                      OP_NOT, OP_XOR, OP_LSHIFT, OP_RSHIFT};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                          |
// | Two-way round-robin grant selection with a remembered last winner.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       grant_id_o
);

  logic last_grant_q;

  // A lone requester wins outright; on contention the previous loser wins.
  always_comb begin
    grant_id_o = req_i[1];
    if (req_i == 2'b11) begin
      grant_id_o = ~last_grant_q;
    end
  end

  // Track the most recent winner; reset to 1 so requester 0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept_i) begin
      last_grant_q <= grant_id_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_arbiter                                                    |
// | Arbitrates two requesters onto one combinational ALU, holds operands |
// | for a fixed execute time and returns the tagged result.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_issue_arbiter #(
  parameter int DATA_W      = alu_pkg::DATA_W,
  parameter int OP_W        = alu_pkg::OP_W,
  parameter int EXEC_CYCLES = 1,
  parameter int MUL_CYCLES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_output,
  input  logic              zero_flag,
  input  logic              negative_flag,
  input  logic              overflow_flag,
  input  logic              carry_flag
);

  import alu_pkg::*;

  localparam int CNT_MAX = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic               rsp_valid_q;
  logic               rsp_id_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic [3:0]         rsp_flags_q;
  logic               rsp_err_q;

  logic               grant_id;
  logic               is_idle;
  logic               accept;
  logic [OP_W-1:0]    op_d;
  logic [DATA_W-1:0]  a_d;
  logic [DATA_W-1:0]  b_d;
  logic [3:0]         flags_d;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req_i      ({req1_valid, req0_valid}),
    .accept_i   (accept),
    .grant_id_o (grant_id)
  );

  assign is_idle    = (state_q == S_IDLE);
  assign req0_ready = is_idle && req0_valid && !grant_id;
  assign req1_ready = is_idle && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  // Operands of the granted requester and the ALU flags packed into response order.
  always_comb begin
    op_d            = grant_id ? req1_op : req0_op;
    a_d             = grant_id ? req1_a  : req0_a;
    b_d             = grant_id ? req1_b  : req0_b;
    flags_d         = '0;
    flags_d[FLAG_Z] = zero_flag;
    flags_d[FLAG_N] = negative_flag;
    flags_d[FLAG_V] = overflow_flag;
    flags_d[FLAG_C] = carry_flag;
  end

  // Sequencer: accept one request, hold it on the ALU for the execute time, then respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rsp_id_q <= grant_id;
            if (op_is_legal(op_d)) begin
              cnt_q   <= (op_d == OP_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(EXEC_CYCLES);
              state_q <= S_EXEC;
            end else begin
              // Illegal opcodes skip the ALU entirely and answer with an error.
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_flags_q  <= '0;
              rsp_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_result_q <= alu_output;
            rsp_flags_q  <= flags_d;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_operation = op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_flags     = rsp_flags_q;
  assign rsp_err       = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_arbiter                                                 |
// | Self-checking bench: vector table, corner sequences, random traffic  |
// | against a transaction-level reference model.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_issue_arbiter;

  localparam int EXEC_C = 1;
  localparam int MUL_C  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_op, req1_op;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [63:0] alu_a, alu_b, alu_output;
  logic [7:0]  alu_operation;
  logic        zero_flag, negative_flag, overflow_flag, carry_flag;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(
    .DATA_W(64), .OP_W(8), .EXEC_CYCLES(EXEC_C), .MUL_CYCLES(MUL_C)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_output(alu_output), .zero_flag(zero_flag), .negative_flag(negative_flag),
    .overflow_flag(overflow_flag), .carry_flag(carry_flag)
  );

  // Behavioural ALU: returns {carry, overflow, negative, zero, result}.
  function automatic logic [67:0] alu_fn(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    logic [63:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; w = '0;
    case (op)
      8'h01: begin w = {1'b0, a} + {1'b0, b}; r = w[63:0]; c = w[64];
                   v = (a[63] == b[63]) && (r[63] != a[63]); end
      8'h02: begin w = {1'b0, a} - {1'b0, b}; r = w[63:0]; c = w[64];
                   v = (a[63] != b[63]) && (r[63] != a[63]); end
      8'h03: r = a * b;
      8'h04: r = a & b;
      8'h05: r = a | b;
      8'h06: r = ~a;
      8'h07: r = a ^ b;
      8'h08: r = a << b[5:0];
      8'h09: r = a >> b[5:0];
      default: r = '0;
    endcase
    return {c, v, r[63], (r == 64'd0), r};
  endfunction

  assign {carry_flag, overflow_flag, negative_flag, zero_flag, alu_output} =
         alu_fn(alu_operation, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_id"}, rsp_id, 0);
    chk({nm, "_rsp_result"}, rsp_result, 0);
    chk({nm, "_rsp_flags"}, rsp_flags, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_alu_a"}, alu_a, 0);
    chk({nm, "_alu_b"}, alu_b, 0);
    chk({nm, "_alu_op"}, alu_operation, 0);
    chk({nm, "_readys"}, {req0_ready, req1_ready}, 0);
  endtask

  typedef struct {
    bit          who;
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  fl;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vt[10];

  // One isolated request: expect immediate grant, operands held during execute, tagged response.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    rsp_ready = 1'b1;
    if (v.who) begin req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
    else       begin req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    #1;
    chk({nm, "_ready"}, v.who ? req1_ready : req0_ready, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      req0_valid = 0; req1_valid = 0;
      #1;
      if (rsp_valid) begin lat = k; break; end
      chk({nm, "_exec_alu_a"}, alu_a, v.a);
      chk({nm, "_exec_alu_b"}, alu_b, v.b);
      chk({nm, "_exec_alu_op"}, alu_operation, v.op);
      chk({nm, "_exec_readys"}, {req0_ready, req1_ready}, 0);
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_id"}, rsp_id, v.who);
    chk({nm, "_result"}, rsp_result, v.res);
    chk({nm, "_flags"}, rsp_flags, v.fl);
    chk({nm, "_err"}, rsp_err, v.err);
    tick();
  endtask

  // Reference-model state for random traffic.
  bit          m_busy, m_last, m_err, m_id;
  int          m_rsp_at;
  logic [63:0] m_res;
  logic [3:0]  m_fl;
  bit          v0, v1, rr, g, rv, e_r0, e_r1;
  logic [7:0]  sop;
  logic [63:0] sa, sb;
  int          w;
  int          lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 8'h01, 64'd15, 64'd10, 64'd25, 4'b0000, 0, 2};
    vt[1] = '{1, 8'h03, 64'd3, 64'd4, 64'd12, 4'b0000, 0, 4};
    vt[2] = '{0, 8'h0A, 64'd5, 64'd6, 64'd0, 4'b0000, 1, 1};
    vt[3] = '{0, 8'h08, 64'd1, 64'd4, 64'h10, 4'b0000, 0, 2};
    vt[4] = '{1, 8'h02, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010, 0, 2};
    vt[5] = '{1, 8'h06, 64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 0, 2};
    vt[6] = '{0, 8'h09, 64'h80, 64'd7, 64'd1, 4'b0000, 0, 2};
    vt[7] = '{1, 8'h01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0110, 0, 2};
    vt[8] = '{0, 8'h05, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 0, 2};
    vt[9] = '{1, 8'h00, 64'd1, 64'd1, 64'd0, 4'b0000, 1, 1};

    rst = 1; rsp_ready = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) tick();
    #1;
    check_reset_vals("reset");
    rst = 0;
    tick();

    // Contention: both valid every cycle, grants must alternate starting with requester 0.
    req0_op = 8'h02; req0_a = 64'd20; req0_b = 64'd10;
    req1_op = 8'h04; req1_a = 64'hF0F0_F0F0_F0F0_F0F0; req1_b = 64'h0F0F_0F0F_0F0F_0F0F;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int gi = 0; gi < 4; gi++) begin
      w = 0;
      #1;
      while (!(req0_ready || req1_ready) && w < 10) begin tick(); #1; w++; end
      chk("cont_ready0", req0_ready, (gi % 2) == 0);
      chk("cont_ready1", req1_ready, (gi % 2) == 1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        tick(); #1;
        if (rsp_valid) begin lat = k; break; end
      end
      chk("cont_latency", lat, 2);
      chk("cont_id", rsp_id, gi % 2);
      chk("cont_result", rsp_result, (gi % 2) ? 64'd0 : 64'd10);
      chk("cont_flags", rsp_flags, (gi % 2) ? 4'b0001 : 4'b0000);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Back-pressure: response must hold and block grants while rsp_ready is low.
    req0_op = 8'h07; req0_a = 64'hFF00_0000_0000_0000; req0_b = 64'h00FF_FFFF_FFFF_FFFF;
    req0_valid = 1; rsp_ready = 0;
    #1;
    chk("bp_accept", req0_ready, 1);
    tick();
    req0_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (rsp_valid) break;
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    for (int h = 0; h < 5; h++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_flags", rsp_flags, 4'b0010);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
      tick(); #1;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    tick(); #1;
    chk("bp_release_valid", rsp_valid, 0);
    req0_valid = 1;
    #1;
    chk("bp_release_idle", req0_ready, 1);
    req0_valid = 0;
    tick();

    // Reset in the second MUL execute cycle aborts the operation.
    req1_op = 8'h03; req1_a = 64'd3; req1_b = 64'd4; req1_valid = 1; rsp_ready = 1;
    #1;
    chk("rstmul_accept", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    rst = 1;
    tick(); #1;
    check_reset_vals("rstmul");
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      chk("rstmul_no_rsp", rsp_valid, 0);
    end
    tick();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rstmul_first_grant0", req0_ready, 1);
    chk("rstmul_first_grant1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    tick();

    // Random traffic against a timestamped transaction model.
    m_busy = 0; m_last = 1; m_rsp_at = 0; m_res = 0; m_fl = 0; m_err = 0; m_id = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      req0_valid = v0; req1_valid = v1; rsp_ready = rr;
      req0_op = 8'($urandom_range(0, 11)); req1_op = 8'($urandom_range(0, 11));
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
      #1;
      e_r0 = !m_busy && v0 && (!v1 || m_last);
      e_r1 = !m_busy && v1 && (!v0 || !m_last);
      rv   = m_busy && (cyc >= m_rsp_at);
      chk("rnd_ready0", req0_ready, e_r0);
      chk("rnd_ready1", req1_ready, e_r1);
      chk("rnd_rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_result", rsp_result, m_res);
        chk("rnd_flags", rsp_flags, m_fl);
        chk("rnd_err", rsp_err, m_err);
      end
      tick();
      if (!m_busy && (v0 || v1)) begin
        g   = (v0 && v1) ? !m_last : v1;
        sop = g ? req1_op : req0_op;
        sa  = g ? req1_a : req0_a;
        sb  = g ? req1_b : req0_b;
        m_last = g; m_id = g; m_busy = 1;
        if (sop >= 8'h01 && sop <= 8'h09) begin
          {m_fl, m_res} = alu_fn(sop, sa, sb);
          m_err    = 0;
          m_rsp_at = cyc + 1 + ((sop == 8'h03) ? MUL_C : EXEC_C);
        end else begin
          m_res = 0; m_fl = 0; m_err = 1;
          m_rsp_at = cyc + 1;
        end
      end else if (rv && rr) begin
        m_busy = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
